// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction-fetch front end. Issues in-order, pipelined requests to program
//   memory (req/grant/rvalid, arbitrary latency), buffers returned words with
//   their PCs in a DEPTH-entry FIFO and offers the head to decode over
//   valid/ready. A redirect flushes the FIFO, restarts fetch at the new PC and
//   marks every in-flight response for discard.
//
//   Handshakes:
//     - Memory request: o_pm_cs/o_pm_addr are offered; the request is taken in
//       the cycle o_pm_cs & i_pm_gnt. Address is held stable while waiting for
//       a grant; cs only drops without a grant on a redirect.
//     - Memory response: i_pm_rvalid/i_pm_data, one word per cycle, returned in
//       request order.
//     - Decode: o_inst/o_inst_pc are valid while o_inst_valid; the head is
//       consumed in the cycle o_inst_valid & i_inst_ready.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-low reset
//   o_pm_addr, o_pm_cs    fetch request address / request valid
//   i_pm_gnt              request accepted
//   i_pm_rvalid, i_pm_data response word
//   o_inst_valid, i_inst_ready, o_inst, o_inst_pc   decode interface
//   i_redirect, i_redirect_pc                       branch redirect
//   o_count               queue occupancy
//   o_err                 sticky protocol error (response with nothing pending)
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    output logic [XLEN-1:0]            o_pm_addr,
    output logic                       o_pm_cs,
    input  logic                       i_pm_gnt,
    input  logic                       i_pm_rvalid,
    input  logic [ILEN-1:0]            i_pm_data,
    output logic                       o_inst_valid,
    input  logic                       i_inst_ready,
    output logic [ILEN-1:0]            o_inst,
    output logic [XLEN-1:0]            o_inst_pc,
    input  logic                       i_redirect,
    input  logic [XLEN-1:0]            i_redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = CW + 2;
    localparam logic [SW-1:0]   DEPTH_W = SW'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

    // Architectural state
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
    logic [CW-1:0]   occ_q,      occ_d;
    logic [CW-1:0]   live_q,     live_d;
    logic [CW-1:0]   disc_q,     disc_d;
    logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic            err_q,      err_d;

    // Queue storage (no reset needed: contents are only read when occ != 0)
    logic [ILEN-1:0] data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic [SW-1:0]   total;
    logic            grant;
    logic            rv_drop;
    logic            rv_push;
    logic            rv_err;
    logic            pop;
    logic            push_en;
    logic [CW-1:0]   disc_after;
    logic [CW-1:0]   live_after;
    logic [XLEN-1:0] redirect_tgt;
    logic            unused_redirect_lsbs;

    // Every granted request already owns a queue slot, so pushes can never
    // overflow: issue is throttled on queue + in-flight (kept or dropped).
    assign total        = {2'b00, occ_q} + {2'b00, live_q} + {2'b00, disc_q};
    assign o_pm_cs      = ~i_redirect & (total < DEPTH_W);
    assign o_pm_addr    = fetch_pc_q;
    assign grant        = o_pm_cs & i_pm_gnt;

    // Responses retire the oldest outstanding request: dropped ones first,
    // since everything marked for discard was issued before any kept request.
    assign rv_drop      = i_pm_rvalid & (disc_q != '0);
    assign rv_push      = i_pm_rvalid & (disc_q == '0) & (live_q != '0);
    assign rv_err       = i_pm_rvalid & (disc_q == '0) & (live_q == '0);
    assign disc_after   = disc_q - CW'(rv_drop);
    assign live_after   = live_q - CW'(rv_push);

    assign o_inst_valid = (occ_q != '0) & ~i_redirect;
    assign pop          = o_inst_valid & i_inst_ready;
    assign push_en      = rv_push & ~i_redirect;

    assign redirect_tgt         = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

    assign o_inst    = data_mem[rd_ptr_q];
    assign o_inst_pc = pc_mem[rd_ptr_q];
    assign o_count   = occ_q;
    assign o_err     = err_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        occ_d      = occ_q;
        live_d     = live_q;
        disc_d     = disc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q | rv_err;

        if (i_redirect) begin
            // A response arriving this cycle is retired first; whatever is
            // still kept-in-flight afterwards becomes discard.
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            occ_d      = '0;
            rd_ptr_d   = wr_ptr_q;
            live_d     = '0;
            disc_d     = disc_after + live_after;
        end else begin
            fetch_pc_d = grant ? fetch_pc_q + PC_STEP : fetch_pc_q;
            live_d     = live_after + CW'(grant);
            disc_d     = disc_after;
            occ_d      = occ_q + CW'(rv_push) - CW'(pop);
            if (rv_push) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                resp_pc_d = resp_pc_q + PC_STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            occ_q      <= '0;
            live_q     <= '0;
            disc_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            occ_q      <= occ_d;
            live_q     <= live_d;
            disc_q     <= disc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_en) begin
            data_mem[wr_ptr_q] <= i_pm_data;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    logic [XLEN-1:0]            o_pm_addr;
    logic                       o_pm_cs;
    logic                       i_pm_gnt;
    logic                       i_pm_rvalid;
    logic [ILEN-1:0]            i_pm_data;
    logic                       o_inst_valid;
    logic                       i_inst_ready;
    logic [ILEN-1:0]            o_inst;
    logic [XLEN-1:0]            o_inst_pc;
    logic                       i_redirect;
    logic [XLEN-1:0]            i_redirect_pc;
    logic [$clog2(DEPTH+1)-1:0] o_count;
    logic                       o_err;

    inst_fetch_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_pm_addr(o_pm_addr), .o_pm_cs(o_pm_cs), .i_pm_gnt(i_pm_gnt),
        .i_pm_rvalid(i_pm_rvalid), .i_pm_data(i_pm_data),
        .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
        .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_count(o_count), .o_err(o_err)
    );

    // ---------------- model state ----------------
    typedef struct packed { logic [XLEN-1:0] pc; logic [ILEN-1:0] data; } ent_t;
    typedef struct packed { logic [XLEN-1:0] pc; logic keep; } req_t;
    typedef struct packed { logic [XLEN-1:0] addr; logic [31:0] due; } mem_t;

    ent_t exp_q[$];   // what decode must see, oldest first
    req_t out_q[$];   // accepted requests not yet answered
    mem_t mem_q[$];   // memory pipeline
    logic [XLEN-1:0] m_fetch;
    logic            m_err;

    // stimulus knobs
    logic            gnt_v, ready_v, redir_v, inj_rv;
    logic [XLEN-1:0] redir_pc_v;
    int              lat;
    int              cyc;
    int              n_tests, n_fail;

    function automatic logic [ILEN-1:0] data_of(input logic [XLEN-1:0] a);
        return a[31:0] ^ 32'hC0DE_5A00;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver + compare + model step ----------------
    task automatic cycle();
        logic mem_rv, e_cs, e_valid;
        req_t r;
        mem_rv        = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        i_pm_gnt      = gnt_v;
        i_inst_ready  = ready_v;
        i_redirect    = redir_v;
        i_redirect_pc = redir_pc_v;
        i_pm_rvalid   = mem_rv | inj_rv;
        i_pm_data     = mem_rv ? data_of(mem_q[0].addr) : 32'hBAD0_BAD0;
        @(negedge i_clk);
        e_cs    = !redir_v && (exp_q.size() + out_q.size() < DEPTH);
        e_valid = (exp_q.size() != 0) && !redir_v;
        check("pm_cs", 64'(o_pm_cs), 64'(e_cs));
        if (e_cs) check("pm_addr", o_pm_addr, m_fetch);
        check("inst_valid", 64'(o_inst_valid), 64'(e_valid));
        if (e_valid) begin
            check("inst_pc", o_inst_pc, exp_q[0].pc);
            check("inst", 64'(o_inst), 64'(exp_q[0].data));
        end
        check("count", 64'(o_count), 64'(exp_q.size()));
        check("err", 64'(o_err), 64'(m_err));
        // memory environment
        if (mem_rv) void'(mem_q.pop_front());
        if (o_pm_cs && i_pm_gnt) mem_q.push_back({o_pm_addr, 32'(cyc + lat)});
        // reference model: pop, then retire a response, then issue
        if (e_valid && ready_v) void'(exp_q.pop_front());
        if (inj_rv || mem_rv) begin
            if (out_q.size() > 0) begin
                r = out_q.pop_front();
                if (r.keep) exp_q.push_back({r.pc, data_of(r.pc)});
            end else begin
                m_err = 1'b1;
            end
        end
        if (redir_v) begin
            exp_q.delete();
            foreach (out_q[i]) out_q[i].keep = 1'b0;
            m_fetch = {redir_pc_v[XLEN-1:2], 2'b00};
        end else if (e_cs && gnt_v) begin
            out_q.push_back({m_fetch, 1'b1});
            m_fetch = m_fetch + 64'd4;
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect_to(input logic [XLEN-1:0] pc);
        redir_v = 1'b1; redir_pc_v = pc;
        cycle();
        redir_v = 1'b0;
    endtask

    task automatic drain();
        int k;
        gnt_v = 1'b0; ready_v = 1'b1; redir_v = 1'b0; inj_rv = 1'b0;
        k = 0;
        while ((mem_q.size() != 0 || out_q.size() != 0 || exp_q.size() != 0) && k < 40) begin
            cycle();
            k++;
        end
        check("drain_timeout", 64'(k < 40), 64'd1);
    endtask

    task automatic wait_head(input string name);
        int k;
        k = 0;
        while (!o_inst_valid && k < 30) begin
            cycle();
            k++;
        end
        check(name, 64'(o_inst_valid), 64'd1);
    endtask

    task automatic model_reset();
        exp_q.delete(); out_q.delete(); mem_q.delete();
        m_fetch = RESET_PC;
        m_err   = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; lat = 1;
        gnt_v = 0; ready_v = 0; redir_v = 0; inj_rv = 0; redir_pc_v = '0;
        i_pm_gnt = 0; i_inst_ready = 0; i_redirect = 0; i_redirect_pc = '0;
        i_pm_rvalid = 0; i_pm_data = '0;
        i_rst = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_valid", 64'(o_inst_valid), 64'd0);
        check("rst_err", 64'(o_err), 64'd0);
        check("rst_addr", o_pm_addr, 64'h0);
        i_rst = 1'b1;

        // 1: streaming with 1-cycle memory
        gnt_v = 1; ready_v = 1; lat = 1;
        check("t1_addr0", o_pm_addr, 64'h0);
        run(2);
        check("t1_head_valid", 64'(o_inst_valid), 64'd1);
        check("t1_head_pc", o_inst_pc, 64'h0);
        check("t1_head_data", 64'(o_inst), 64'h0000_0000_C0DE_5A00);
        run(12);

        // 2: backpressure fills the queue, then drains in order
        drain();
        redirect_to(64'h0);
        gnt_v = 1; ready_v = 0;
        run(8);
        check("t2_count_full", 64'(o_count), 64'd4);
        check("t2_cs_low", 64'(o_pm_cs), 64'd0);
        check("t2_head_pc", o_inst_pc, 64'h0);
        ready_v = 1;
        run(10);

        // 3: random grant stalls and random decode backpressure
        drain();
        redirect_to(64'h200);
        for (int i = 0; i < 60; i++) begin
            gnt_v   = ($urandom_range(0, 3) == 0);
            ready_v = ($urandom_range(0, 3) != 0);
            lat     = $urandom_range(1, 3);
            cycle();
        end
        lat = 1;

        // 4: two requests in flight, redirect to a misaligned target
        drain();
        redirect_to(64'h20);
        lat = 3; gnt_v = 1; ready_v = 1;
        run(2);
        gnt_v = 0;
        redirect_to(64'h103);
        gnt_v = 1;
        wait_head("t4_head_timeout");
        check("t4_head_pc", o_inst_pc, 64'h100);
        check("t4_head_data", 64'(o_inst), 64'(data_of(64'h100)));
        run(6);

        // 5: three back-to-back redirects with 4-cycle memory
        drain();
        redirect_to(64'h0);
        lat = 4; gnt_v = 1; ready_v = 1;
        run(3);
        redirect_to(64'h40);
        redirect_to(64'h80);
        redirect_to(64'hC0);
        wait_head("t5_head_timeout");
        check("t5_head_pc", o_inst_pc, 64'hC0);
        run(10);
        lat = 1;

        // 6: spurious response sets sticky error; then reset mid-burst
        drain();
        redirect_to(64'h300);
        gnt_v = 1; ready_v = 0;
        run(2);
        gnt_v = 0;
        run(4);
        check("t6_count_before", 64'(o_count), 64'd2);
        inj_rv = 1;
        cycle();
        inj_rv = 0;
        check("t6_err_set", 64'(o_err), 64'd1);
        check("t6_count_kept", 64'(o_count), 64'd2);
        run(4);
        check("t6_err_sticky", 64'(o_err), 64'd1);
        gnt_v = 1; ready_v = 1;
        run(3);
        #2;
        i_rst = 1'b0;
        #1;
        check("t6_rst_valid", 64'(o_inst_valid), 64'd0);
        check("t6_rst_count", 64'(o_count), 64'd0);
        check("t6_rst_err", 64'(o_err), 64'd0);
        check("t6_rst_addr", o_pm_addr, RESET_PC);
        model_reset();
        i_pm_rvalid = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        gnt_v = 1; ready_v = 1;
        run(6);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
